// File: rtl/vec_wb_collector.sv
// rtl/vec_wb_collector.sv - gathers vec_alu lane slices into one VLEN-bit register
// and hands the completed register to the vector register file over valid/ready.
module vec_wb_collector #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 5,
  parameter int MAX_LANES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                vsew,
  input  logic [1:0]                nb_lanes,
  input  logic [MAX_LANES-1:0]      lane_valid,
  input  logic [MAX_LANES*VLEN-1:0] lane_vd,
  input  logic [MAX_LANES*10-1:0]   lane_idx,
  output logic [VLEN-1:0]           out_vd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      err
);

  localparam int NB = VLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_t;

  state_t               state, state_n;
  logic [VLEN-1:0]      acc, acc_n;
  logic [NB-1:0]        mask, mask_n;
  logic                 err_q, err_n;
  logic [1:0]           vsew_l, vsew_n;
  logic [1:0]           nbl_l, nbl_n;

  logic [6:0]           w_bits;
  logic [3:0]           w_bytes;
  logic [VLEN-1:0]      bit_ones;
  logic [NB-1:0]        byte_ones;
  logic [MAX_LANES-1:0] lane_act;
  logic [NB-1:0]        claimed;
  logic [9:0]           idx;
  logic [VLEN-1:0]      dmask;
  logic [NB-1:0]        bmask;
  logic                 legal;
  logic                 start_ok;

  logic unused_lane_width;
  assign unused_lane_width = ^LANE_WIDTH;

  assign w_bits   = 7'd8 << vsew_l;
  assign w_bytes  = 4'd1 << vsew_l;
  assign start_ok = start && (vsew <= 3'd3);

  always_comb begin
    bit_ones  = '0;
    byte_ones = '0;
    lane_act  = '0;
    for (int b = 0; b < VLEN; b++) bit_ones[b] = (b < int'(w_bits));
    for (int b = 0; b < NB; b++) byte_ones[b] = (b < int'(w_bytes));
    for (int i = 0; i < MAX_LANES; i++) lane_act[i] = (i < (32'd1 << nbl_l));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mask_n  = mask;
    err_n   = err_q;
    vsew_n  = vsew_l;
    nbl_n   = nbl_l;
    claimed = '0;
    idx     = '0;
    dmask   = '0;
    bmask   = '0;
    legal   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          acc_n   = '0;
          mask_n  = '0;
          err_n   = 1'b0;
          vsew_n  = vsew[1:0];
          nbl_n   = nb_lanes;
          state_n = S_COLLECT;
        end else if (start) begin
          err_n = 1'b1;
        end
      end
      S_COLLECT: begin
        // Walk lanes high to low so the lowest lane's write lands last and wins.
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
          if (lane_valid[i] && lane_act[i]) begin
            idx   = lane_idx[i*10 +: 10];
            legal = ((idx & {3'd0, w_bits - 7'd1}) == 10'd0) &&
                    (({1'b0, idx} + {4'd0, w_bits}) <= 11'(VLEN));
            if (!legal) begin
              err_n = 1'b1;
            end else begin
              dmask = bit_ones << idx;
              bmask = byte_ones << idx[9:3];
              if ((bmask & (mask | claimed)) != '0) err_n = 1'b1;
              acc_n   = (acc_n & ~dmask) | (lane_vd[i*VLEN +: VLEN] & dmask);
              mask_n  = mask_n | bmask;
              claimed = claimed | bmask;
            end
          end
        end
        if (&mask_n) state_n = S_OUTPUT;
      end
      S_OUTPUT: begin
        if ((lane_valid & lane_act) != '0) err_n = 1'b1;
        if (out_ready) begin
          if (start_ok) begin
            acc_n   = '0;
            mask_n  = '0;
            err_n   = 1'b0;
            vsew_n  = vsew[1:0];
            nbl_n   = nb_lanes;
            state_n = S_COLLECT;
          end else begin
            if (start) err_n = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mask   <= '0;
      err_q  <= 1'b0;
      vsew_l <= '0;
      nbl_l  <= '0;
    end else begin
      acc    <= acc_n;
      mask   <= mask_n;
      err_q  <= err_n;
      vsew_l <= vsew_n;
      nbl_l  <= nbl_n;
    end
  end

  assign out_vd    = acc;
  assign out_valid = (state == S_OUTPUT);
  assign busy      = (state != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_vec_wb_collector.sv
// tb/tb_vec_wb_collector.sv - directed checks of vec_wb_collector with hand-computed values.
module tb_vec_wb_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   vsew;
  logic [1:0]   nb_lanes;
  logic [3:0]   lane_valid;
  logic [511:0] lane_vd;
  logic [39:0]  lane_idx;
  logic [127:0] out_vd;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_vd;
  logic [127:0] held_vd;
  logic [127:0] va, vb, vc, vdd;

  vec_wb_collector #(.VLEN(128), .LANE_WIDTH(5), .MAX_LANES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .vsew(vsew), .nb_lanes(nb_lanes),
    .lane_valid(lane_valid), .lane_vd(lane_vd), .lane_idx(lane_idx),
    .out_vd(out_vd), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [9:0] idx, input logic [127:0] vd);
    lane_valid[i]         = v;
    lane_idx[i*10 +: 10]  = idx;
    lane_vd[i*128 +: 128] = vd;
  endtask

  task automatic do_start(input logic [2:0] sew, input logic [1:0] nbl);
    start = 1'b1; vsew = sew; nb_lanes = nbl;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vsew = '0; nb_lanes = '0;
    lane_valid = '0; lane_vd = '0; lane_idx = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check_eq("rst_out_vd", out_vd, '0);
    check_eq("rst_out_valid", 128'(out_valid), 0);
    check_eq("rst_busy", 128'(busy), 0);
    check_eq("rst_err", 128'(err), 0);

    // 32-bit elements, 4 lanes, one cycle fills the register
    va = 128'habcdabcdbeefbeef1234567887654321;
    do_start(3'd2, 2'd2);
    check_eq("t1_busy", 128'(busy), 1);
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 10'(i * 32), va);
    step();
    lane_valid = '0;
    check_eq("t1_valid", 128'(out_valid), 1);
    check_eq("t1_vd", out_vd, va);
    check_eq("t1_err", 128'(err), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("t1_drop", 128'(out_valid), 0);
    check_eq("t1_idle", 128'(busy), 0);

    // bytes, 4 lanes, 4 cycles; byte k comes from lane k%4 whose pattern is A0+lane
    do_start(3'd0, 2'd2);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 10'((c * 4 + i) * 8), {16{8'(8'hA0 + i)}});
      step();
      if (c == 2) check_eq("t2_not_yet", 128'(out_valid), 0);
    end
    lane_valid = '0;
    for (int k = 0; k < 16; k++) exp_vd[k*8 +: 8] = 8'(8'hA0 + (k % 4));
    check_eq("t2_valid", 128'(out_valid), 1);
    check_eq("t2_vd", out_vd, exp_vd);
    held_vd = exp_vd;
    for (int h = 0; h < 3; h++) begin
      step();
      check_eq("t2_hold_valid", 128'(out_valid), 1);
      check_eq("t2_hold_vd", out_vd, held_vd);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("t2_drop", 128'(out_valid), 0);
    check_eq("t2_err", 128'(err), 0);

    // 64-bit elements, one lane; lane1 traffic must be ignored
    va = 128'h11112222333344445555666677778888;
    vb = 128'h99990000aaaabbbbccccddddeeeeffff;
    vc = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    do_start(3'd3, 2'd0);
    set_lane(0, 1'b1, 10'd0, va);
    set_lane(1, 1'b1, 10'd64, vc);
    step();
    check_eq("t3_one_slice", 128'(out_valid), 0);
    set_lane(0, 1'b1, 10'd64, vb);
    set_lane(1, 1'b1, 10'd0, vc);
    step();
    lane_valid = '0;
    check_eq("t3_valid", 128'(out_valid), 1);
    check_eq("t3_vd", out_vd, 128'h99990000aaaabbbb5555666677778888);
    check_eq("t3_err", 128'(err), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 32-bit: misaligned drop, then duplicate idx 0, then fill the rest
    vc  = 128'h0123456789abcdef0123456789abcdef;
    vdd = 128'hfedcba9876543210fedcba9876543210;
    do_start(3'd2, 2'd0);
    set_lane(0, 1'b1, 10'd16, 128'hffffffffffffffffffffffffffffffff);
    step();
    check_eq("t4_misalign_err", 128'(err), 1);
    check_eq("t4_misalign_vd", out_vd, '0);
    set_lane(0, 1'b1, 10'd0, vc);
    step();
    set_lane(0, 1'b1, 10'd0, vdd);
    step();
    check_eq("t4_dup_err", 128'(err), 1);
    set_lane(0, 1'b1, 10'd32, vdd);
    step();
    set_lane(0, 1'b1, 10'd64, vdd);
    step();
    check_eq("t4_not_done", 128'(out_valid), 0);
    set_lane(0, 1'b1, 10'd96, vdd);
    step();
    lane_valid = '0;
    check_eq("t4_valid", 128'(out_valid), 1);
    check_eq("t4_vd", out_vd, vdd);

    // back-to-back: handshake and new start (16-bit) in the same cycle
    out_ready = 1'b1;
    start = 1'b1; vsew = 3'd1; nb_lanes = 2'd2;
    step();
    start = 1'b0; out_ready = 1'b0;
    check_eq("t5_busy", 128'(busy), 1);
    check_eq("t5_valid", 128'(out_valid), 0);
    check_eq("t5_err", 128'(err), 0);
    check_eq("t5_acc_clear", out_vd, '0);
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 10'(i * 16), {8{16'(16'h1000 + i)}});
    step();
    check_eq("t5_half", 128'(out_valid), 0);
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 10'((4 + i) * 16), {8{16'(16'h2000 + i)}});
    step();
    lane_valid = '0;
    check_eq("t5_valid_done", 128'(out_valid), 1);
    check_eq("t5_vd", out_vd, 128'h20032002200120001003100210011000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    do_start(3'd5, 2'd0);
    check_eq("t5_bad_sew_err", 128'(err), 1);
    check_eq("t5_bad_sew_busy", 128'(busy), 0);

    // reset in the middle of a collection
    do_start(3'd2, 2'd0);
    check_eq("t6_err_cleared", 128'(err), 0);
    set_lane(0, 1'b1, 10'd0, va);
    step();
    set_lane(0, 1'b1, 10'd32, va);
    step();
    lane_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6_vd", out_vd, '0);
    check_eq("t6_valid", 128'(out_valid), 0);
    check_eq("t6_busy", 128'(busy), 0);
    check_eq("t6_err", 128'(err), 0);
    do_start(3'd2, 2'd2);
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 10'(i * 32), vb);
    step();
    lane_valid = '0;
    check_eq("t6_after_valid", 128'(out_valid), 1);
    check_eq("t6_after_vd", out_vd, vb);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("t6_after_idle", 128'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_wb_collector.md
Name: vec_wb_collector

Overview:
- Write-back end of the vec_alu lane interface.
- Consumes per-lane results (vd slice, reg_index, valid) from up to 4 vec_alu instances and assembles them into one VLEN-bit destination register.
- Tracks which bytes have been written and presents the completed register to the vector register file through a valid/ready handshake.
- Replaces the ad-hoc slice gathering that benches and the core currently do by hand.

Parameters:
- VLEN, 128, vector register width in bits (multiple of 64).
- LANE_WIDTH, 5, log2 of lane datapath width in bits. Carried for consistency with vec_alu; it does not change slice width.
- MAX_LANES, 4, number of lane input ports.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin collecting one destination register. Honoured only in IDLE, or in OUTPUT on the cycle the output handshake completes.
- vsew  input  3  element width code, 0..3 = 8/16/32/64 bits. Latched on accepted start.
- nb_lanes  input  2  log2 of active lanes. Active count = min(1<<nb_lanes, MAX_LANES). Latched on accepted start.
- lane_valid  input  MAX_LANES  per-lane result strobe (vec_alu done/step).
- lane_vd  input  MAX_LANES*VLEN  lane i vd at bits [i*VLEN +: VLEN].
- lane_idx  input  MAX_LANES*10  lane i reg_index (bit offset) at [i*10 +: 10].
- out_vd  output  VLEN  assembled register.
- out_valid  output  1  out_vd complete and stable.
- out_ready  input  1  consumer accepts out_vd.
- busy  output  1  high in COLLECT or OUTPUT.
- err  output  1  sticky protocol error flag; cleared by reset or by an accepted start.

Behaviour:
- Reset: state IDLE. out_vd=0, out_valid=0, busy=0, err=0, byte mask=0.
- Slice width: W = 8<<vsew_l, where vsew_l is the latched vsew.
  - Slice for lane i = lane_vd_i[idx_i +: W], written to acc[idx_i +: W].
- Byte mask: one bit per byte, VLEN/8 bits.
- IDLE:
  - start with vsew<=3: clear acc, clear mask, clear err, latch vsew/nb_lanes; go to COLLECT next cycle.
  - start with vsew>3: stay IDLE, set err.
  - lane_valid is ignored in IDLE, including on the start cycle.
- COLLECT:
  - Each cycle, every active lane with lane_valid=1 writes its slice in parallel (up to 4 slices per cycle).
  - An inactive lane's lane_valid is ignored.
  - Rejection: if idx_i is not a multiple of W, or idx_i+W > VLEN, that slice is dropped and err is set.
  - Overwrite: a slice touching any byte already set in the mask is still written and sets err. Lowest lane index wins if two lanes overlap in the same cycle.
  - Completion: when the mask becomes all-ones at an edge, the next state is OUTPUT. out_valid rises in the cycle after the last slice is sampled (1-cycle latency), and out_vd = acc.
- OUTPUT:
  - out_vd and out_valid stay stable until out_ready=1.
  - Handshake (out_valid & out_ready) at an edge: out_valid drops next cycle and state returns to IDLE.
  - If start is also high that cycle with a legal vsew: go directly to COLLECT, clearing acc/mask/err and latching the new vsew/nb_lanes (back-to-back, no idle bubble).
  - Any active lane_valid in OUTPUT is ignored and sets err.
- start in COLLECT: ignored, no effect on err.
- Reset mid-operation: returns to reset values on the next edge and discards any partial register.
- busy = (state != IDLE).
- Slices per register = VLEN/W. There is no element counter; completion is mask-based only.

Test Plan:
- VLEN=128, vsew=2, nb_lanes=2, start.
  - Cycle 1: all 4 lanes valid with idx 0/32/64/96 and lane_vd=128'habcdabcdbeefbeef1234567887654321.
  - Required: out_valid=1 the next cycle, out_vd equal to that value, err=0.
- vsew=0, nb_lanes=2.
  - Stimulus: 4 cycles of 4 valid lanes covering idx 0..120 in steps of 8, with out_ready held 0 for 3 cycles after out_valid rises.
  - Required: out_vd held stable while out_ready=0; out_valid drops 1 cycle after out_ready=1.
- vsew=3, nb_lanes=0.
  - Stimulus: lane0 idx 0, then idx 64.
  - Required: out_valid only after the second slice.
  - Also drive lane1 valid: it is ignored.
- vsew=2.
  - Stimulus: lane0 idx 16 (misaligned) -> dropped, err=1.
  - Then: idx 0 twice -> err stays 1, completion still requires the remaining bytes.
- Back-to-back: in OUTPUT, assert out_ready and start (vsew=1) in the same cycle.
  - Required: next cycle busy=1, out_valid=0, err=0, mask clear.
  - Also: start with vsew=5 in IDLE -> err=1, busy=0.
- Assert reset mid-COLLECT after 2 of 4 slices.
  - Required: next cycle all outputs 0.
  - A following full collection completes normally.
